mem_access_sequencer: RTL

//   Owns the single physical data-memory port and retires the control unit's dual logical

---
 rtl/mem_seq_pkg.sv | 39 +++
 rtl/mem_seq_rr_arbiter.sv | 38 +++
 rtl/mem_access_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types for the memory access sequencer: FSM states, port owner,
// per-port operation encoding and the supported memory latency range.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DBG
  } owner_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_RD,
    OP_WR
  } op_t;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 3;

  // Read+write on the same port behaves as a write.
  function automatic op_t decode_op(input logic rd, input logic wr);
    if (wr) return OP_WR;
    if (rd) return OP_RD;
    return OP_NONE;
  endfunction

  function automatic int clamp_lat(input int lat);
    if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
    if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/mem_seq_rr_arbiter.sv
// Two-requester round-robin grant between the control unit and the display reader.
// The last-served flag moves only when a transaction leaves DONE.
module mem_seq_rr_arbiter
  import mem_seq_pkg::*;
(
  input  logic   CLK,
  input  logic   RESET_n,
  input  logic   cpu_req,
  input  logic   dbg_req,
  input  logic   served,
  input  owner_t served_owner,
  output logic   grant_valid,
  output owner_t grant
);

  owner_t last_q;

  // Resetting to DBG makes the CPU win the first contested grant.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      last_q <= OWN_DBG;
    end else if (served) begin
      last_q <= served_owner;
    end
  end

  always_comb begin
    grant_valid = cpu_req | dbg_req;
    if (cpu_req && dbg_req) begin
      grant = (last_q == OWN_CPU) ? OWN_DBG : OWN_CPU;
    end else if (cpu_req) begin
      grant = OWN_CPU;
    end else begin
      grant = OWN_DBG;
    end
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Serialises the control unit's two logical accesses and the display reader onto one memory port.
// Optional build macro MEM_SEQ_FWD_EN: a port-2 read of the address port 1 just wrote is served from wdata1.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | no transaction; arbitrate between cpu_req and dbg_req
//   ST_ISSUE | mem_en high for the current access (write retires here)
//   ST_WAIT  | read in flight, down-counting MEM_LAT cycles to capture
//   ST_DONE  | all accesses retired; pulse cpu_done or dbg_ack on exit
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RESET_n,
  input  logic              cpu_req,
  input  logic              MemRead1,
  input  logic              MemWrite1,
  input  logic              MemRead2,
  input  logic              MemWrite2,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic              cpu_stall,
  output logic              cpu_done,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int         LAT       = clamp_lat(MEM_LAT);
  localparam logic [1:0] WAIT_LOAD = 2'(LAT - 1);

  state_t              state;
  owner_t              owner;
  logic                port_sel;
  logic [1:0]          wait_cnt;
  op_t                 op2_q;
  logic [ADDR_W-1:0]   addr2_q;
  logic [DATA_W-1:0]   wdata2_q;
  logic                fwd_q;

  op_t                 op1_in;
  op_t                 op2_in;
  logic                fwd_in;
  logic                step_done;
  logic                p2_pending;
  logic                grant_valid;
  owner_t              grant;

  assign op1_in = decode_op(MemRead1, MemWrite1);
  assign op2_in = decode_op(MemRead2, MemWrite2);

`ifdef MEM_SEQ_FWD_EN
  assign fwd_in = (op1_in == OP_WR) && (op2_in == OP_RD) && (addr1 == addr2);
`else
  assign fwd_in = 1'b0;
`endif

  // The current access retires at this edge: a write leaving ISSUE or a read's last WAIT cycle.
  assign step_done  = ((state == ST_ISSUE) && mem_we) ||
                      ((state == ST_WAIT) && (wait_cnt == 2'd0));
  assign p2_pending = (owner == OWN_CPU) && !port_sel && (op2_q != OP_NONE) && !fwd_q;

  mem_seq_rr_arbiter u_arb (
    .CLK          (CLK),
    .RESET_n      (RESET_n),
    .cpu_req      (cpu_req),
    .dbg_req      (dbg_req),
    .served       (state == ST_DONE),
    .served_owner (owner),
    .grant_valid  (grant_valid),
    .grant        (grant)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state     <= ST_IDLE;
      owner     <= OWN_CPU;
      port_sel  <= 1'b0;
      wait_cnt  <= 2'd0;
      op2_q     <= OP_NONE;
      addr2_q   <= '0;
      wdata2_q  <= '0;
      fwd_q     <= 1'b0;
      cpu_stall <= 1'b0;
      cpu_done  <= 1'b0;
      rdata1    <= '0;
      rdata2    <= '0;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      cpu_done  <= 1'b0;
      dbg_ack   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;

      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            owner    <= grant;
            port_sel <= 1'b0;
            if (grant == OWN_DBG) begin
              state    <= ST_ISSUE;
              mem_en   <= 1'b1;
              mem_addr <= dbg_addr;
            end else begin
              cpu_stall <= 1'b1;
              op2_q     <= op2_in;
              addr2_q   <= addr2;
              wdata2_q  <= wdata2;
              fwd_q     <= fwd_in;
              if (op1_in != OP_NONE) begin
                state     <= ST_ISSUE;
                mem_en    <= 1'b1;
                mem_we    <= (op1_in == OP_WR);
                mem_addr  <= addr1;
                mem_wdata <= (op1_in == OP_WR) ? wdata1 : '0;
              end else if (op2_in != OP_NONE) begin
                port_sel  <= 1'b1;
                state     <= ST_ISSUE;
                mem_en    <= 1'b1;
                mem_we    <= (op2_in == OP_WR);
                mem_addr  <= addr2;
                mem_wdata <= (op2_in == OP_WR) ? wdata2 : '0;
              end else begin
                state <= ST_DONE;
              end
            end
          end
        end

        ST_ISSUE: begin
          if (mem_we) begin
            if (port_sel) rdata2 <= mem_wdata;
            else          rdata1 <= mem_wdata;
          end else begin
            state    <= ST_WAIT;
            wait_cnt <= WAIT_LOAD;
          end
        end

        ST_WAIT: begin
          if (wait_cnt == 2'd0) begin
            if (owner == OWN_DBG) dbg_rdata <= mem_rdata;
            else if (port_sel)    rdata2    <= mem_rdata;
            else                  rdata1    <= mem_rdata;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          if (owner == OWN_CPU) begin
            cpu_done  <= 1'b1;
            cpu_stall <= 1'b0;
          end else begin
            dbg_ack <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase

      // Advance to port 2 or wrap up; a forwarded port-2 read takes wdata1 still on mem_wdata.
      if (step_done) begin
        if (p2_pending) begin
          port_sel  <= 1'b1;
          state     <= ST_ISSUE;
          mem_en    <= 1'b1;
          mem_we    <= (op2_q == OP_WR);
          mem_addr  <= addr2_q;
          mem_wdata <= (op2_q == OP_WR) ? wdata2_q : '0;
        end else begin
          state <= ST_DONE;
          if (fwd_q && !port_sel && (owner == OWN_CPU)) rdata2 <= mem_wdata;
        end
      end
    end
  end

endmodule
